// File: rtl/banco_registradores_pkg.sv
// Shared processor constants: datapath widths and ALU opcodes.
// Imported by the register file, the control unit and the ALU.
package pacote_processador;

    localparam int LARGURA_DADO = 16;
    localparam int N_REGS       = 8;
    localparam int LARG_END_REG = 3;

    localparam logic [LARG_END_REG-1:0] REG_ZERO = 3'd0;

    localparam logic [2:0] ULA_ADD = 3'b000;
    localparam logic [2:0] ULA_SUB = 3'b001;
    localparam logic [2:0] ULA_SLT = 3'b010;
    localparam logic [2:0] ULA_SLL = 3'b011;
    localparam logic [2:0] ULA_SRL = 3'b100;
    localparam logic [2:0] ULA_AND = 3'b101;

endpackage

// File: rtl/banco_registradores_if.sv
// Register-file bus: one write port, two stallable read ports.
// The master is the control/writeback side; the slave is the register file.
interface banco_registradores_if
    import pacote_processador::*;
#(
    parameter int LARGURA = LARGURA_DADO,
    parameter int N_REGS  = pacote_processador::N_REGS
);
    localparam int LE = $clog2(N_REGS);

    logic               EscreveReg;
    logic [LE-1:0]      RegEscrita;
    logic [LARGURA-1:0] DadoEscrita;
    logic               LeRegs;
    logic [LE-1:0]      RegLeitura1;
    logic [LE-1:0]      RegLeitura2;
    logic [LARGURA-1:0] Dado1;
    logic [LARGURA-1:0] Dado2;

    modport master (
        output EscreveReg, RegEscrita, DadoEscrita,
        output LeRegs, RegLeitura1, RegLeitura2,
        input  Dado1, Dado2
    );

    modport slave (
        input  EscreveReg, RegEscrita, DadoEscrita,
        input  LeRegs, RegLeitura1, RegLeitura2,
        output Dado1, Dado2
    );

endinterface

// File: rtl/banco_registradores.sv
// Register file with r0 hardwired to zero, registered read ports
// and a write-to-read bypass on each port.
module banco_registradores
    import pacote_processador::*;
#(
    parameter int LARGURA = LARGURA_DADO,
    parameter int N_REGS  = pacote_processador::N_REGS
) (
    input logic                  clock,
    input logic                  reset,
    banco_registradores_if.slave bus
);
    localparam int LE = $clog2(N_REGS);

    logic [LARGURA-1:0] r_regs [N_REGS];
    logic [LARGURA-1:0] r_dado1;
    logic [LARGURA-1:0] r_dado2;

    logic w_escreve;
    logic w_byp1;
    logic w_byp2;

    // r0 is never a write target, so its flop stays at the reset value
    assign w_escreve = bus.EscreveReg && (bus.RegEscrita != LE'(0));
    assign w_byp1    = w_escreve && (bus.RegEscrita == bus.RegLeitura1);
    assign w_byp2    = w_escreve && (bus.RegEscrita == bus.RegLeitura2);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_escreve) begin
            r_regs[bus.RegEscrita] <= bus.DadoEscrita;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dado1 <= '0;
        end else if (bus.LeRegs) begin
            if (bus.RegLeitura1 == LE'(0)) begin
                r_dado1 <= '0;
            end else if (w_byp1) begin
                r_dado1 <= bus.DadoEscrita;
            end else begin
                r_dado1 <= r_regs[bus.RegLeitura1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dado2 <= '0;
        end else if (bus.LeRegs) begin
            if (bus.RegLeitura2 == LE'(0)) begin
                r_dado2 <= '0;
            end else if (w_byp2) begin
                r_dado2 <= bus.DadoEscrita;
            end else begin
                r_dado2 <= r_regs[bus.RegLeitura2];
            end
        end
    end

    assign bus.Dado1 = r_dado1;
    assign bus.Dado2 = r_dado2;

endmodule

// File: tb/tb_banco_registradores.sv
// Bench for banco_registradores: directed scenarios plus random traffic
// compared against an array-based reference model.
module tb_banco_registradores;
    import pacote_processador::*;

    logic clock = 1'b0;
    logic reset;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [8];
    logic [15:0] exp1;
    logic [15:0] exp2;

    banco_registradores_if #(.LARGURA(16), .N_REGS(8)) bus ();

    banco_registradores #(.LARGURA(16), .N_REGS(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // What a read of address a returns at this edge, given this cycle's write
    function automatic logic [15:0] visible(input logic [2:0] a,
                                            input logic we,
                                            input logic [2:0] wa,
                                            input logic [15:0] wd);
        if (a == 3'd0) return 16'h0000;
        if (we && wa == a) return wd;
        return mem[a];
    endfunction

    // One clock: drive inputs, advance the model, compare both ports
    task automatic cyc(input string tag, input logic rst, input logic we,
                       input logic [2:0] wa, input logic [15:0] wd,
                       input logic le, input logic [2:0] a1,
                       input logic [2:0] a2);
        reset           = rst;
        bus.EscreveReg  = we;
        bus.RegEscrita  = wa;
        bus.DadoEscrita = wd;
        bus.LeRegs      = le;
        bus.RegLeitura1 = a1;
        bus.RegLeitura2 = a2;
        if (rst) begin
            foreach (mem[i]) mem[i] = 16'h0000;
            exp1 = 16'h0000;
            exp2 = 16'h0000;
        end else begin
            if (le) begin
                exp1 = visible(a1, we, wa, wd);
                exp2 = visible(a2, we, wa, wd);
            end
            if (we && wa != 3'd0) mem[wa] = wd;
        end
        @(posedge clock);
        #1;
        check({tag, ".d1"}, bus.Dado1, exp1);
        check({tag, ".d2"}, bus.Dado2, exp2);
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 16'hxxxx;
        exp1 = 16'h0000;
        exp2 = 16'h0000;

        cyc("rst0", 1, 0, 0, 0, 0, 0, 0);
        cyc("rst1", 1, 0, 0, 0, 0, 0, 0);
        check("reset_d1", bus.Dado1, 16'h0000);

        for (int r = 1; r < 8; r++) begin
            cyc("fill", 0, 1, 3'(r), 16'hFFFF, 0, 0, 0);
        end
        cyc("rst_clr", 1, 0, 0, 0, 1, 3, 4);
        check("rst_clr_d1", bus.Dado1, 16'h0000);
        for (int r = 0; r < 8; r++) begin
            cyc("rd_after_rst", 0, 0, 0, 0, 1, 3'(r), 3'(7 - r));
            check("rst_rd_d1", bus.Dado1, 16'h0000);
            check("rst_rd_d2", bus.Dado2, 16'h0000);
        end

        cyc("wr_r3", 0, 1, 3, 16'h1234, 0, 0, 0);
        cyc("rd_r3r5", 0, 0, 0, 0, 1, 3, 5);
        check("basic_d1", bus.Dado1, 16'h1234);
        check("basic_d2", bus.Dado2, 16'h0000);

        cyc("byp", 0, 1, 6, 16'hBEEF, 1, 6, 6);
        check("byp_d1", bus.Dado1, 16'hBEEF);
        check("byp_d2", bus.Dado2, 16'hBEEF);
        cyc("byp_store", 0, 0, 0, 0, 1, 6, 6);
        check("byp_store", bus.Dado2, 16'hBEEF);

        cyc("r0_wr", 0, 1, 0, 16'hAAAA, 1, 0, 0);
        check("r0_byp", bus.Dado1, 16'h0000);
        cyc("r0_rd", 0, 0, 0, 0, 1, 0, 0);
        check("r0_later", bus.Dado2, 16'h0000);

        cyc("wr_r2", 0, 1, 2, 16'h0042, 0, 0, 0);
        cyc("rd_r2", 0, 0, 0, 0, 1, 2, 0);
        check("stall_pre", bus.Dado1, 16'h0042);
        for (int k = 0; k < 3; k++) begin
            cyc("stall", 0, 1, 2, 16'h0099, 0, 2, 0);
            check("stall_hold", bus.Dado1, 16'h0042);
        end
        cyc("unstall", 0, 0, 0, 0, 1, 2, 0);
        check("stall_release", bus.Dado1, 16'h0099);

        cyc("wr_r5", 0, 1, 5, 16'h1111, 0, 0, 0);
        cyc("rd_r5", 0, 0, 0, 0, 1, 5, 5);
        check("pre_stall_rst", bus.Dado2, 16'h1111);
        cyc("stall_rst", 1, 0, 0, 0, 0, 5, 5);
        check("stall_rst", bus.Dado1, 16'h0000);

        cyc("wr_r4", 0, 1, 4, 16'h7777, 0, 0, 0);
        cyc("rst_pend", 1, 1, 4, 16'h7777, 1, 4, 4);
        cyc("rd_r4", 0, 0, 0, 0, 1, 4, 0);
        check("rst_pend_r4", bus.Dado1, 16'h0000);

        for (int n = 0; n < 400; n++) begin
            cyc("rand", ($urandom_range(31) == 0),
                1'($urandom), 3'($urandom), 16'($urandom),
                ($urandom_range(3) != 0),
                3'($urandom), 3'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
